// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared types and constants for the 68k CPU-side bus bridge.
//   bridge_state_e : IDLE / REQ / DONE access sequencing
//   FC_*           : 68k function code encodings
//   LANE_*         : bit positions inside a 16-bit byte-enable pair
//   HALF_*         : which 16-bit half a 32-bit word access uses (addr[1])
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_e;

  localparam logic [2:0] FC_USER_DATA = 3'd1;
  localparam logic [2:0] FC_USER_PROG = 3'd2;
  localparam logic [2:0] FC_SUPV_DATA = 3'd5;
  localparam logic [2:0] FC_SUPV_PROG = 3'd6;
  localparam logic [2:0] FC_CPU_SPACE = 3'd7;

  // Big-endian: the even byte (UDS, D15:8) is the MSB of a byte-enable pair.
  localparam int LANE_EVEN = 1;
  localparam int LANE_ODD  = 0;

  // addr[1] value selecting each half of a 32-bit memory word.
  localparam logic HALF_UPPER = 1'b0;
  localparam logic HALF_LOWER = 1'b1;

endpackage

// File: rtl/m68k_lane_steer.sv
// m68k_lane_steer: combinational byte-lane steering between the 16-bit 68k
// data bus and a 16- or 32-bit memory data path.
//   addr1     : word-in-longword select (only meaningful for 32-bit memory)
//   uds, lds  : active-low byte strobes
//   cpu_wdata : core write data        -> wdata : memory write data
//   mem_rdata : memory read data       -> rdata : read data to the core
//   be        : active-high byte enables, MSB = lowest address
module m68k_lane_steer
  import m68k_bus_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = 16
) (
  input  logic                        addr1,
  input  logic                        uds,
  input  logic                        lds,
  input  logic [15:0]                 cpu_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata,
  output logic [MEM_DATA_WIDTH/8-1:0] be,
  output logic [MEM_DATA_WIDTH-1:0]   wdata,
  output logic [15:0]                 rdata
);

  logic [1:0] be16;

  always_comb begin
    be16            = '0;
    be16[LANE_EVEN] = ~uds;
    be16[LANE_ODD]  = ~lds;
  end

  generate
    if (MEM_DATA_WIDTH == 32) begin : g_w32
      // Replicated write data lets the byte enables alone pick the half.
      assign be    = (addr1 == HALF_LOWER) ? {2'b00, be16} : {be16, 2'b00};
      assign wdata = {cpu_wdata, cpu_wdata};
      assign rdata = (addr1 == HALF_LOWER) ? mem_rdata[15:0] : mem_rdata[31:16];
    end else begin : g_w16
      logic unused_addr1;
      assign unused_addr1 = addr1;
      assign be    = be16;
      assign wdata = cpu_wdata;
      assign rdata = mem_rdata[15:0];
    end
  endgenerate

endmodule

// File: rtl/m68k_bus_bridge.sv
// m68k_bus_bridge: 68k core-side bus to valid/ready memory bus bridge.
// The core is stalled through cpu_clk_en while an access is outstanding.
//   clk, reset_in      : clock, async active-high reset
//   clk_en             : global enable, gates cpu_clk_en
//   cpu_*              : core address/fc/strobes/direction/data, berr back
//   mem_valid/ready    : request handshake; mem_err qualified by mem_ready
//   mem_addr/fc/we/be/wdata : request fields, held stable through REQ
//   mem_rdata          : read data, steered onto cpu_data_in
// A REQ that sees no mem_ready for TIMEOUT_CYCLES cycles ends with a bus error.
module m68k_bus_bridge
  import m68k_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_EN     = 1
) (
  input  logic                        clk,
  input  logic                        reset_in,
  input  logic                        clk_en,
  input  logic [31:0]                 cpu_addr,
  input  logic [2:0]                  cpu_fc,
  input  logic [15:0]                 cpu_data_out,
  input  logic                        cpu_uds,
  input  logic                        cpu_lds,
  input  logic                        cpu_read,
  input  logic                        cpu_write,
  output logic                        cpu_clk_en,
  output logic [15:0]                 cpu_data_in,
  output logic                        cpu_berr,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [2:0]                  mem_fc,
  output logic                        mem_we,
  output logic [MEM_DATA_WIDTH/8-1:0] mem_be,
  output logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata,
  input  logic                        mem_err
);

  localparam int BW = MEM_DATA_WIDTH / 8;
  localparam int AL = $clog2(BW);  // address bits dropped for alignment

  bridge_state_e state, state_nxt;

  logic                      access, start, timeout;
  logic                      a1_q;
  logic [15:0]               tmo_cnt;
  logic                      st_a1;
  logic [BW-1:0]             st_be;
  logic [MEM_DATA_WIDTH-1:0] st_wdata;
  logic [15:0]               st_rdata;

  // cpu_read only mirrors cpu_write; addr[0] and the high bits are don't-care.
  logic unused_in;
  assign unused_in = ^{cpu_addr, cpu_read};

  assign access  = ~cpu_uds | ~cpu_lds;
  assign start   = clk_en & access;
  assign timeout = (TIMEOUT_EN != 0) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Live addr[1] while latching the request, the latched copy for read data.
  assign st_a1 = (state == ST_IDLE) ? cpu_addr[1] : a1_q;

  m68k_lane_steer #(.MEM_DATA_WIDTH(MEM_DATA_WIDTH)) u_steer (
    .addr1     (st_a1),
    .uds       (cpu_uds),
    .lds       (cpu_lds),
    .cpu_wdata (cpu_data_out),
    .mem_rdata (mem_rdata),
    .be        (st_be),
    .wdata     (st_wdata),
    .rdata     (st_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state; mem_ready beats a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)                state_nxt = ST_REQ;
      ST_REQ:  if (mem_ready || timeout) state_nxt = ST_DONE;
      ST_DONE: if (clk_en)               state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    mem_valid  = 1'b0;
    cpu_clk_en = 1'b0;
    case (state)
      ST_IDLE: cpu_clk_en = clk_en & ~access;
      ST_REQ:  mem_valid  = 1'b1;
      ST_DONE: cpu_clk_en = clk_en;
      default: ;
    endcase
  end

  // Request latch, timeout counter, response capture
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      mem_addr    <= '0;
      mem_fc      <= '0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      a1_q        <= 1'b0;
      tmo_cnt     <= '0;
      cpu_data_in <= '0;
      cpu_berr    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          mem_addr  <= {cpu_addr[ADDR_WIDTH-1:AL], {AL{1'b0}}};
          mem_fc    <= cpu_fc;
          mem_we    <= cpu_write;
          mem_be    <= st_be;
          mem_wdata <= st_wdata;
          a1_q      <= cpu_addr[1];
          tmo_cnt   <= '0;
        end
        ST_REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (mem_ready) begin
            if (!mem_we) cpu_data_in <= st_rdata;
            cpu_berr <= mem_err;
          end else if (timeout) begin
            cpu_berr <= 1'b1;
          end
        end
        ST_DONE: if (clk_en) cpu_berr <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_bridge.sv
// Drives a 16-bit and a 32-bit bridge with identical core-side traffic and
// checks both against a byte-offset reference model.
module tb_m68k_bus_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] cpu_addr;
  logic [2:0]  cpu_fc;
  logic [15:0] cpu_data_out;
  logic        uds, lds, cpu_read, cpu_write;
  logic        mem_ready, mem_err;
  logic [15:0] rd16;
  logic [31:0] rd32;

  logic        a_cen, a_berr, a_val, a_we;
  logic [15:0] a_din, a_wd;
  logic [23:0] a_addr;
  logic [2:0]  a_fc;
  logic [1:0]  a_be;
  logic        b_cen, b_berr, b_val, b_we;
  logic [15:0] b_din;
  logic [31:0] b_wd;
  logic [23:0] b_addr;
  logic [2:0]  b_fc;
  logic [3:0]  b_be;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp16 = '0, exp32 = '0;

  always #5 clk = ~clk;

  m68k_bus_bridge #(.ADDR_WIDTH(24), .MEM_DATA_WIDTH(16), .TIMEOUT_CYCLES(TMO), .TIMEOUT_EN(1)) u16 (
    .clk(clk), .reset_in(rst), .clk_en(clk_en), .cpu_addr(cpu_addr), .cpu_fc(cpu_fc),
    .cpu_data_out(cpu_data_out), .cpu_uds(uds), .cpu_lds(lds), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_clk_en(a_cen), .cpu_data_in(a_din), .cpu_berr(a_berr),
    .mem_valid(a_val), .mem_ready(mem_ready), .mem_addr(a_addr), .mem_fc(a_fc), .mem_we(a_we),
    .mem_be(a_be), .mem_wdata(a_wd), .mem_rdata(rd16), .mem_err(mem_err));

  m68k_bus_bridge #(.ADDR_WIDTH(24), .MEM_DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO), .TIMEOUT_EN(1)) u32 (
    .clk(clk), .reset_in(rst), .clk_en(clk_en), .cpu_addr(cpu_addr), .cpu_fc(cpu_fc),
    .cpu_data_out(cpu_data_out), .cpu_uds(uds), .cpu_lds(lds), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_clk_en(b_cen), .cpu_data_in(b_din), .cpu_berr(b_berr),
    .mem_valid(b_val), .mem_ready(mem_ready), .mem_addr(b_addr), .mem_fc(b_fc), .mem_we(b_we),
    .mem_be(b_be), .mem_wdata(b_wd), .mem_rdata(rd32), .mem_err(mem_err));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Core-visible outputs of both bridges
  task automatic chk_cpu(input string tag, input logic cen, input logic berr, input logic val);
    chk({tag, "_cen16"}, 64'(a_cen), 64'(cen));
    chk({tag, "_cen32"}, 64'(b_cen), 64'(cen));
    chk({tag, "_berr16"}, 64'(a_berr), 64'(berr));
    chk({tag, "_berr32"}, 64'(b_berr), 64'(berr));
    chk({tag, "_val16"}, 64'(a_val), 64'(val));
    chk({tag, "_val32"}, 64'(b_val), 64'(val));
    chk({tag, "_din16"}, 64'(a_din), 64'(exp16));
    chk({tag, "_din32"}, 64'(b_din), 64'(exp32));
  endtask

  task automatic idle_inputs();
    uds = 1'b1; lds = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
    mem_ready = 1'b0; mem_err = 1'b0;
  endtask

  // One core access. wait_n = REQ cycles before mem_ready (>= TMO: never).
  // done_hold = extra DONE cycles with clk_en low.
  task automatic do_access(input logic [31:0] addr, input logic u, input logic l,
                           input logic we, input logic [15:0] wd, input logic [2:0] fc,
                           input int wait_n, input logic err, input logic [15:0] r16,
                           input logic [31:0] r32, input int done_hold);
    logic [23:0] ea16, ea32;
    logic [1:0]  ebe16;
    logic [3:0]  ebe32;
    logic        tmo, eberr;
    int          nreq;
    ea16  = addr[23:0] & ~24'h1;
    ea32  = addr[23:0] & ~24'h3;
    ebe16 = '0;
    ebe32 = '0;
    // byte offset of each active strobe inside the memory word, MSB = offset 0
    for (int b = 0; b < 2; b++)
      if ((b == 0) ? !u : !l) begin
        ebe16 |= 2'(1 << (1 - b));
        ebe32 |= 4'(1 << (3 - (2 * int'(addr[1]) + b)));
      end
    tmo  = (wait_n >= TMO);
    nreq = tmo ? TMO : wait_n + 1;

    cpu_addr = addr; uds = u; lds = l; cpu_write = we; cpu_read = ~we;
    cpu_data_out = wd; cpu_fc = fc; clk_en = 1'b1;
    rd16 = r16; rd32 = r32; mem_err = err; mem_ready = (wait_n == 0);
    #1;
    chk("idle_cen16", 64'(a_cen), 64'd0);
    chk("idle_cen32", 64'(b_cen), 64'd0);
    @(posedge clk);
    for (int k = 0; k < nreq; k++) begin
      @(negedge clk);
      // request must have been latched: scramble the core side
      cpu_addr = $urandom; cpu_data_out = 16'($urandom); cpu_fc = 3'($urandom);
      mem_ready = (k == wait_n);
      #1;
      chk("req_val16", 64'(a_val), 64'd1);
      chk("req_val32", 64'(b_val), 64'd1);
      chk("req_cen16", 64'(a_cen), 64'd0);
      chk("req_cen32", 64'(b_cen), 64'd0);
      chk("req_addr16", 64'(a_addr), 64'(ea16));
      chk("req_addr32", 64'(b_addr), 64'(ea32));
      chk("req_be16", 64'(a_be), 64'(ebe16));
      chk("req_be32", 64'(b_be), 64'(ebe32));
      chk("req_we16", 64'(a_we), 64'(we));
      chk("req_we32", 64'(b_we), 64'(we));
      chk("req_wd16", 64'(a_wd), 64'(wd));
      chk("req_wd32", 64'(b_wd), 64'(32'(wd) * 32'h0001_0001));
      chk("req_fc16", 64'(a_fc), 64'(fc));
      chk("req_fc32", 64'(b_fc), 64'(fc));
    end
    @(negedge clk);
    mem_ready = 1'b0; uds = 1'b1; lds = 1'b1;
    clk_en = (done_hold == 0);
    if (!tmo && !we) begin
      exp16 = r16;
      exp32 = 16'(r32 >> (addr[1] ? 0 : 16));
    end
    eberr = tmo ? 1'b1 : err;
    #1 chk_cpu("done", clk_en, eberr, 1'b0);
    for (int h = 1; h <= done_hold; h++) begin
      @(negedge clk);
      clk_en = (h == done_hold);
      #1 chk_cpu("hold", clk_en, eberr, 1'b0);
    end
    @(negedge clk);
    clk_en = 1'b1;
    #1 chk_cpu("back", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; cpu_addr = '0; cpu_fc = '0; cpu_data_out = '0;
    rd16 = '0; rd32 = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1 chk_cpu("rst", 1'b1, 1'b0, 1'b0);
    chk("rst_addr16", 64'(a_addr), 64'd0);
    chk("rst_be32", 64'(b_be), 64'd0);
    chk("rst_wd32", 64'(b_wd), 64'd0);
    chk("rst_we16", 64'(a_we), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: zero-wait read, odd-byte write, wait states, errors, races
    do_access(32'h0000_1000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd5, 0, 1'b0, 16'hBEEF, 32'hBEEF_1234, 0);
    do_access(32'h0000_0006, 1'b1, 1'b0, 1'b1, 16'h12AB, 3'd1, 0, 1'b0, 16'h0, 32'h0, 0);
    do_access(32'h00AB_CDE2, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd2, 5, 1'b0, 16'h5A5A, 32'hCAFE_F00D, 0);
    do_access(32'h0012_3404, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd6, 99, 1'b0, 16'h1111, 32'h2222_3333, 1);
    do_access(32'h0000_0100, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd5, 2, 1'b1, 16'h7777, 32'h8888_9999, 0);
    do_access(32'hFF80_0042, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd7, TMO - 1, 1'b0, 16'hA1B2, 32'hC3D4_E5F6, 0);
    do_access(32'h0000_0202, 1'b0, 1'b0, 1'b1, 16'h4321, 3'd1, TMO, 1'b0, 16'h0, 32'h0, 2);

    // clk_en low keeps an active strobe from starting an access
    uds = 1'b0; clk_en = 1'b0;
    #1 chk_cpu("gated", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk_cpu("gated2", 1'b0, 1'b0, 1'b0);
    idle_inputs(); clk_en = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] s;
      int w;
      s = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 6))
        0: w = 0; 1: w = 1; 2: w = 2; 3: w = 3;
        4: w = TMO - 1; 5: w = TMO; default: w = 20;
      endcase
      do_access($urandom, s[1], s[0], 1'($urandom), 16'($urandom), 3'($urandom), w,
                ($urandom_range(0, 3) == 0), 16'($urandom), $urandom, $urandom_range(0, 2));
    end

    // Reset in the middle of a stalled request
    cpu_addr = 32'h0000_3456; uds = 1'b0; lds = 1'b0; cpu_write = 1'b1;
    cpu_data_out = 16'hFACE; clk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("pre_rst_val16", 64'(a_val), 64'd1);
    rst = 1'b1; idle_inputs();
    #1;
    exp16 = '0; exp32 = '0;
    chk_cpu("midrst", 1'b1, 1'b0, 1'b0);
    chk("midrst_be16", 64'(a_be), 64'd0);
    chk("midrst_addr32", 64'(b_addr), 64'd0);
    chk("midrst_wd16", 64'(a_wd), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_access(32'h0000_0010, 1'b0, 1'b0, 1'b0, 16'h0, 3'd5, 1, 1'b0, 16'h0F0F, 32'h1357_9BDF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m68k_bus_bridge.md
Name: m68k_bus_bridge

Overview:
- Sits between the 68k core wrapper's CPU-side bus (active-low byte strobes, read/write, berr, clk_en) and a generic valid/ready memory bus.
- Stalls the core through its clock enable while an access is outstanding, and steers 68k big-endian byte lanes onto a 16- or 32-bit memory data path.
- Returns a bus error on a memory error response or on a wait-state timeout.
- Replaces the direct core-to-memory hookup in the top level.

Parameters:
- ADDR_WIDTH, 24: width of mem_addr, taken from the low bits of cpu_addr.
- MEM_DATA_WIDTH, 16: memory data path width. Legal values are 16 and 32.
- TIMEOUT_CYCLES, 255: cycles in REQ before the bridge aborts with a bus error. Range 1..65535.
- TIMEOUT_EN, 1: 0 disables the timeout, so REQ waits indefinitely.

Ports:
- clk  input  1  system clock.
- reset_in  input  1  asynchronous, active-high reset.
- clk_en  input  1  global enable; ANDed into cpu_clk_en.
- cpu_addr  input  32  core byte address.
- cpu_fc  input  3  core function code.
- cpu_data_out  input  16  core write data.
- cpu_uds  input  1  active-low upper strobe (D15:8, even byte).
- cpu_lds  input  1  active-low lower strobe (D7:0, odd byte).
- cpu_read  input  1  high = read access.
- cpu_write  input  1  high = write access.
- cpu_clk_en  output  1  clock enable to the core.
- cpu_data_in  output  16  read data to the core.
- cpu_berr  output  1  bus error to the core.
- mem_valid  output  1  request valid.
- mem_ready  input  1  request accepted/completed.
- mem_addr  output  ADDR_WIDTH  byte address, aligned to MEM_DATA_WIDTH/8.
- mem_fc  output  3  latched function code.
- mem_we  output  1  write enable.
- mem_be  output  MEM_DATA_WIDTH/8  active-high byte enables; MSB = lowest address.
- mem_wdata  output  MEM_DATA_WIDTH  write data.
- mem_rdata  input  MEM_DATA_WIDTH  read data.
- mem_err  input  1  error response, qualified by mem_ready.

Behaviour:
- Clock and reset: single clock clk. reset_in is asynchronous and active-high.
- Access detect: access = ~cpu_uds | ~cpu_lds. Direction is taken from cpu_write. cpu_read is informational; both high is treated as a write.
- States IDLE, REQ, DONE; reset to IDLE.
- Reset values: cpu_data_in=0, cpu_berr=0, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- IDLE:
  - cpu_clk_en = clk_en & ~access (combinational).
  - If clk_en & access: latch addr, fc, strobes, direction and write data; go to REQ.
- REQ:
  - mem_valid=1. All mem_* outputs stay stable until the cycle mem_ready is sampled high.
  - cpu_clk_en=0.
  - The counter increments each cycle.
  - On mem_ready: capture read data (steered) into cpu_data_in if this was a read; set cpu_berr=mem_err; go to DONE.
  - Timeout: if TIMEOUT_EN and the counter reaches TIMEOUT_CYCLES-1 without mem_ready, drop mem_valid, set cpu_berr=1, leave cpu_data_in unchanged, go to DONE.
  - mem_ready in the same cycle as timeout expiry: ready wins, no timeout error.
- DONE:
  - cpu_clk_en = clk_en for one cycle.
  - cpu_data_in and cpu_berr are valid this cycle.
  - If clk_en=1, go to IDLE and clear cpu_berr. If clk_en=0, hold DONE.
  - Each enabled core cycle with an active strobe is a new access; there is no strobe-release requirement.
- Minimum latency with zero wait states: 3 cycles (IDLE detect, REQ with ready, DONE).
- Lane steering, MEM_DATA_WIDTH=16:
  - mem_addr = {addr[ADDR_WIDTH-1:1],0}.
  - mem_be = {~uds,~lds}.
  - wdata = cpu_data_out.
  - rdata passes straight through.
- Lane steering, MEM_DATA_WIDTH=32:
  - mem_addr = {addr[ADDR_WIDTH-1:2],00}.
  - addr[1]=0 selects the upper half: be={~uds,~lds,0,0}, rdata[31:16].
  - addr[1]=1 selects the lower half: be={0,0,~uds,~lds}, rdata[15:0].
  - wdata = {cpu_data_out,cpu_data_out}.
- Read data for unselected bytes passes through unmasked.
- reset_in mid-REQ: mem_valid drops immediately. The outstanding memory transaction is abandoned; the memory side must tolerate this.
- cpu_addr[0] is ignored; the strobes define the bytes.

Decomposition:
- Shared package m68k_bus_pkg holds:
  - the bridge state enum (IDLE/REQ/DONE);
  - FC encodings (user/supervisor data/program, CPU space);
  - lane index constants.
- One sub-module: m68k_lane_steer, purely combinational. It maps addr[1], strobes and data in both directions for a given MEM_DATA_WIDTH.

Test Plan:
- Read, 16-bit, zero wait: cpu_addr=0x001000, uds=lds=0, read; mem_ready high on the first REQ cycle with rdata=0xBEEF -> mem_be=11, cpu_clk_en low 2 cycles, cpu_data_in=0xBEEF in DONE, cpu_berr=0.
- Write, 32-bit, odd byte: addr=0x000006, uds=1, lds=0, data_out=0x12AB -> mem_addr=0x000004, mem_be=0001, mem_wdata=0x12AB12AB, mem_we=1.
- Wait states: mem_ready delayed 5 cycles -> mem_valid and mem_addr stable for all 6 REQ cycles, cpu_clk_en low throughout, single DONE pulse.
- Timeout: TIMEOUT_CYCLES=8, mem_ready never asserted -> mem_valid drops after 8 REQ cycles, cpu_berr=1 in DONE, cpu_data_in unchanged.
- Error response and the ready/timeout race: mem_err=1 with mem_ready -> cpu_berr=1. mem_ready exactly on cycle 8 with TIMEOUT_CYCLES=8 -> cpu_berr=0, data captured.
- Reset mid-REQ, and clk_en=0 in DONE: reset_in pulse mid-REQ -> mem_valid=0 asynchronously, IDLE, outputs at reset values. clk_en=0 in DONE -> state held, cpu_berr held until clk_en returns.
